alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width of operands and results.
REQ-002 The block SHALL have parameter REG_BITS, default 5, register-specifier width.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-006 The block SHALL have port in_valid  input  1  decoded instruction present.
REQ-007 The block SHALL have port in_ready  output  1  block can accept this cycle.
REQ-008 The block SHALL have ports in_a, in_b  input  WIDTH each  register-file values for rs, rt.
REQ-009 The block SHALL have ports in_imm  input  16  immediate; in_use_imm  input  1  B from immediate; in_sign_ext  input  1  sign (1) or zero (0) extend.
REQ-010 The block SHALL have port in_alu_op  input  2  ALU operation select (00 AND, 01 OR, 10 XOR, 11 NOR).
REQ-011 The block SHALL have ports in_rs, in_rt, in_rd  input  REG_BITS each; in_we  input  1  destination write enable.
REQ-012 The block SHALL have ports fwd_valid  input  1; fwd_reg  input  REG_BITS; fwd_data  input  WIDTH  result-forwarding port from the later stage.
REQ-013 The block SHALL have ports out_valid  output  1; out_ready  input  1  ALU-side handshake.
REQ-014 The block SHALL have ports out_a, out_b  output  WIDTH; out_alu_op  output  2; out_rd  output  REG_BITS; out_we  output  1, all registered.

Function
REQ-015 A transfer SHALL occur on the input when in_valid and in_ready are both 1, and on the output when out_valid and out_ready are both 1, at the rising edge.
REQ-016 Storage SHALL be a 2-entry skid buffer (head, skid) with state EMPTY, ONE, TWO; outputs always drive the head entry.
REQ-017 Transitions: EMPTY+in->ONE; ONE+in, no out->TWO; ONE+out, no in->EMPTY; ONE+in+out->ONE; TWO+out->ONE (skid moves to head); no other change holds state.
REQ-018 in_ready SHALL be a registered signal equal to 1 in EMPTY and ONE, 0 in TWO; in_valid while in_ready=0 SHALL be ignored.
REQ-019 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY; head contents SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 Input-to-output latency SHALL be exactly one cycle when EMPTY (out_valid rises the cycle after acceptance).
REQ-021 Immediate extension: in_sign_ext=1 replicates in_imm[15] into bits WIDTH-1:16; in_sign_ext=0 fills zeros.
REQ-022 At acceptance A SHALL be fwd_data if fwd_valid, fwd_reg==in_rs and in_rs!=0, else in_a.
REQ-023 At acceptance B SHALL be the extended immediate if in_use_imm=1; else fwd_data if fwd_valid, fwd_reg==in_rt and in_rt!=0; else in_b.
REQ-024 Each held entry SHALL store rs, rt and use_imm and SHALL snoop the forward port every cycle: a matching non-zero rs (rt, when use_imm=0) replaces the stored A (B) with fwd_data at the edge.
REQ-025 Snooping SHALL apply to an entry in the same cycle it moves from skid to head.
REQ-026 Register 0 SHALL never be forwarded; fwd_reg=0 has no effect.
REQ-027 flush=1 SHALL set state EMPTY at the edge, dropping any same-cycle input, and SHALL take priority over all transfers; reset takes priority over flush.
REQ-028 The block SHALL perform no arithmetic; operand bits pass through unmodified apart from REQ-021..REQ-024.

Reset
REQ-029 With reset=1 at a rising edge: state EMPTY, out_valid=0, in_ready=1, out_a=0, out_b=0, out_alu_op=00, out_rd=0, out_we=0.
REQ-030 Reset asserted mid-operation SHALL discard both entries with no output transfer in that cycle.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 Accept in_a=0x0000_00F0, in_b=0x0000_0F0F, op=01 when EMPTY, out_ready=1 -> next cycle out_valid=1, out_a=0xF0, out_b=0xF0F, out_alu_op=01.
REQ-033 in_imm=0x8001, use_imm=1, sign_ext=1 -> out_b=0xFFFF_8001; sign_ext=0 -> out_b=0x0000_8001.
REQ-034 in_rs=3, in_a=0x11, same cycle fwd_valid=1, fwd_reg=3, fwd_data=0xABCD -> out_a=0xABCD; repeat with rs=0, fwd_reg=0 -> out_a=0x11.
REQ-035 out_ready=0, push 2 entries -> in_ready=0 next cycle, third in_valid ignored; fwd_reg matches skid rt, then out_ready=1 -> entries drained in order, second shows forwarded B.
REQ-036 State TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry emitted.
REQ-037 State ONE, reset=1 with out_ready=1 -> next cycle all outputs at REQ-029 values, no transfer counted.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ALU issue stage: two-entry skid buffer between decode and the ALU that
// extends immediates, selects forwarded operands and keeps held operands fresh.
module alu_issue_stage #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic [15:0]         in_imm,
  input  logic                in_use_imm,
  input  logic                in_sign_ext,
  input  logic [1:0]          in_alu_op,
  input  logic [REG_BITS-1:0] in_rs,
  input  logic [REG_BITS-1:0] in_rt,
  input  logic [REG_BITS-1:0] in_rd,
  input  logic                in_we,
  input  logic                fwd_valid,
  input  logic [REG_BITS-1:0] fwd_reg,
  input  logic [WIDTH-1:0]    fwd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_a,
  output logic [WIDTH-1:0]    out_b,
  output logic [1:0]          out_alu_op,
  output logic [REG_BITS-1:0] out_rd,
  output logic                out_we,
  output logic [1:0]          dbg_state
);

  // Handshake: a word moves on a port at the rising edge where its valid and
  // ready are both 1; ready never depends combinationally on valid.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  typedef struct packed {
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [1:0]          op;
    logic [REG_BITS-1:0] rd;
    logic [REG_BITS-1:0] rs;
    logic [REG_BITS-1:0] rt;
    logic                we;
    logic                use_imm;
  } entry_t;

  state_t state;
  entry_t head, skid, head_snp, skid_snp, new_ent;
  logic   in_fire, out_fire;
  logic   fwd_live;

  // Register 0 is hard-wired, so a forward targeting it is never taken.
  assign fwd_live = fwd_valid && (fwd_reg != '0);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  function automatic entry_t snoop(input entry_t e, input logic live,
                                   input logic [REG_BITS-1:0] fr,
                                   input logic [WIDTH-1:0] fd);
    entry_t r;
    r = e;
    if (live && e.rs == fr) r.a = fd;
    if (live && !e.use_imm && e.rt == fr) r.b = fd;
    return r;
  endfunction

  always_comb begin
    new_ent         = '0;
    new_ent.op      = in_alu_op;
    new_ent.rd      = in_rd;
    new_ent.rs      = in_rs;
    new_ent.rt      = in_rt;
    new_ent.we      = in_we;
    new_ent.use_imm = in_use_imm;
    new_ent.a       = (fwd_live && in_rs == fwd_reg) ? fwd_data : in_a;
    if (in_use_imm)
      new_ent.b = {{(WIDTH-16){in_sign_ext & in_imm[15]}}, in_imm};
    else
      new_ent.b = (fwd_live && in_rt == fwd_reg) ? fwd_data : in_b;
    head_snp = snoop(head, fwd_live, fwd_reg, fwd_data);
    skid_snp = snoop(skid, fwd_live, fwd_reg, fwd_data);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      head      <= '0;
      skid      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      head <= head_snp;
      skid <= skid_snp;
      case (state)
        EMPTY: begin
          if (in_fire) begin
            head      <= new_ent;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            skid     <= new_ent;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (out_fire && !in_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end else if (in_fire && out_fire) begin
            head <= new_ent;
          end
        end
        TWO: begin
          // The skid entry is snooped on its way into the head slot.
          if (out_fire) begin
            head     <= skid_snp;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_a      = head.a;
  assign out_b      = head.b;
  assign out_alu_op = head.op;
  assign out_rd     = head.rd;
  assign out_we     = head.we;
  assign dbg_state  = state;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios then random traffic, checked
// against a queue model of in-flight instructions.
module tb_alu_issue_stage;
  localparam int W = 32;
  localparam int R = 5;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic [15:0]  in_imm;
  logic         in_use_imm, in_sign_ext;
  logic [1:0]   in_alu_op;
  logic [R-1:0] in_rs, in_rt, in_rd;
  logic         in_we, fwd_valid;
  logic [R-1:0] fwd_reg;
  logic [W-1:0] fwd_data;
  logic         out_valid, out_ready;
  logic [W-1:0] out_a, out_b;
  logic [1:0]   out_alu_op;
  logic [R-1:0] out_rd;
  logic         out_we;
  logic [1:0]   dbg_state;

  alu_issue_stage #(.WIDTH(W), .REG_BITS(R)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_sign_ext(in_sign_ext),
    .in_alu_op(in_alu_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_we(in_we), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
    .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op),
    .out_rd(out_rd), .out_we(out_we), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic [1:0]   op;
    logic [R-1:0] rd, rs, rt;
    logic         we, use_imm;
  } ent_t;

  ent_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   was_reset;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    reset = 0; flush = 0; in_valid = 0; out_ready = 1;
    in_a = 0; in_b = 0; in_imm = 0; in_use_imm = 0; in_sign_ext = 0;
    in_alu_op = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_we = 0;
    fwd_valid = 0; fwd_reg = 0; fwd_data = 0;
  endtask

  task automatic drive_in(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input logic [R-1:0] rs,
                          input logic [R-1:0] rt, input logic [R-1:0] rd);
    in_valid = 1; in_a = a; in_b = b; in_alu_op = op;
    in_rs = rs; in_rt = rt; in_rd = rd; in_we = 1; in_use_imm = 0;
  endtask

  function automatic bit fwd_hits(input logic [R-1:0] r);
    return fwd_valid && fwd_reg != 0 && fwd_reg == r;
  endfunction

  // Model: list of instructions waiting, oldest first; each edge refreshes
  // register operands from the forward port, retires one, admits one.
  task automatic step();
    ent_t n;
    bit   take_in, take_out;
    @(posedge clk);
    was_reset = reset;
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      take_out = exp_q.size() > 0 && out_ready;
      take_in  = in_valid && exp_q.size() < 2;
      n.op = in_alu_op; n.rd = in_rd; n.rs = in_rs; n.rt = in_rt;
      n.we = in_we; n.use_imm = in_use_imm;
      n.a = fwd_hits(in_rs) ? fwd_data : in_a;
      if (in_use_imm)
        n.b = in_sign_ext ? W'($signed(in_imm)) : W'(in_imm);
      else
        n.b = fwd_hits(in_rt) ? fwd_data : in_b;
      foreach (exp_q[i]) begin
        if (fwd_hits(exp_q[i].rs)) exp_q[i].a = fwd_data;
        if (!exp_q[i].use_imm && fwd_hits(exp_q[i].rt)) exp_q[i].b = fwd_data;
      end
      if (take_out) void'(exp_q.pop_front());
      if (take_in) exp_q.push_back(n);
    end
    @(negedge clk);
    chk("out_valid", W'(out_valid), W'(exp_q.size() > 0));
    chk("in_ready", W'(in_ready), W'(exp_q.size() < 2));
    if (exp_q.size() > 0) begin
      chk("out_a", out_a, exp_q[0].a);
      chk("out_b", out_b, exp_q[0].b);
      chk("out_alu_op", W'(out_alu_op), W'(exp_q[0].op));
      chk("out_rd", W'(out_rd), W'(exp_q[0].rd));
      chk("out_we", W'(out_we), W'(exp_q[0].we));
    end
    if (was_reset) begin
      chk("rst_out_a", out_a, 0);
      chk("rst_out_b", out_b, 0);
      chk("rst_op", W'(out_alu_op), 0);
      chk("rst_rd", W'(out_rd), 0);
      chk("rst_we", W'(out_we), 0);
    end
  endtask

  initial begin
    drive_idle();
    reset = 1;
    step(); step();
    reset = 0;
    step();
    chk("ready_after_reset", W'(in_ready), 1);

    // Basic pass-through with one-cycle latency.
    drive_in(32'h0000_00F0, 32'h0000_0F0F, 2'b01, 1, 2, 9);
    step();
    chk("basic_a", out_a, 32'hF0);
    chk("basic_b", out_b, 32'hF0F);
    chk("basic_op", W'(out_alu_op), 1);
    drive_idle(); step();

    // Immediate extension both ways.
    drive_in(0, 32'h5555, 2'b10, 1, 2, 3);
    in_imm = 16'h8001; in_use_imm = 1; in_sign_ext = 1;
    step();
    chk("imm_sext", out_b, 32'hFFFF_8001);
    in_sign_ext = 0;
    step();
    chk("imm_zext", out_b, 32'h0000_8001);
    drive_idle(); step();

    // Acceptance-time forwarding, and register 0 never forwarded.
    drive_in(32'h11, 0, 2'b00, 3, 4, 5);
    fwd_valid = 1; fwd_reg = 3; fwd_data = 32'hABCD;
    step();
    chk("fwd_rs3", out_a, 32'hABCD);
    drive_in(32'h11, 0, 2'b00, 0, 4, 5);
    fwd_valid = 1; fwd_reg = 0; fwd_data = 32'hABCD;
    step();
    chk("fwd_rs0", out_a, 32'h11);
    drive_idle(); step();

    // Fill both slots with the ALU stalled, then snoop the skid entry.
    out_ready = 0;
    drive_in(32'hA1, 32'hB1, 2'b00, 2, 1, 6); step();
    drive_in(32'hA2, 32'h22, 2'b11, 4, 7, 8); step();
    chk("full_ready", W'(in_ready), 0);
    drive_in(32'hA3, 32'hB3, 2'b01, 5, 5, 9); step();
    in_valid = 0; fwd_valid = 1; fwd_reg = 7; fwd_data = 32'h7777; out_ready = 1;
    step();
    chk("drain1_rd", W'(out_rd), 8);
    chk("drain1_b_fwd", out_b, 32'h7777);
    fwd_valid = 0; step();
    chk("drain_empty", W'(out_valid), 0);

    // Flush in TWO drops everything including the same-cycle input.
    out_ready = 0;
    drive_in(1, 2, 2'b00, 1, 1, 1); step(); step();
    flush = 1; in_valid = 1; step();
    chk("flush_valid", W'(out_valid), 0);
    chk("flush_ready", W'(in_ready), 1);
    drive_idle(); step();

    // Reset while holding one entry and the ALU ready.
    drive_in(32'hDEAD, 32'hBEEF, 2'b11, 1, 2, 3); step();
    in_valid = 0; reset = 1; out_ready = 1; step();
    reset = 0; step();

    // Random traffic with narrow register numbers so forwards hit often.
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 63) == 0);
      flush       = ($urandom_range(0, 23) == 0);
      in_valid    = $urandom_range(0, 1);
      out_ready   = ($urandom_range(0, 3) != 0);
      in_a        = $urandom; in_b = $urandom;
      in_imm      = 16'($urandom);
      in_use_imm  = $urandom_range(0, 1);
      in_sign_ext = $urandom_range(0, 1);
      in_alu_op   = 2'($urandom);
      in_rs       = R'($urandom_range(0, 3));
      in_rt       = R'($urandom_range(0, 3));
      in_rd       = R'($urandom);
      in_we       = $urandom_range(0, 1);
      fwd_valid   = $urandom_range(0, 1);
      fwd_reg     = R'($urandom_range(0, 3));
      fwd_data    = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
